// File: rtl/avaliador_nota_tempo_pkg.sv
// avaliador_nota_tempo_pkg: FSM state codes and width helpers for the note/duration evaluator.
// Rev 1.0
`default_nettype none

package avaliador_nota_tempo_pkg;

  // The state codes are also the values driven on db_estado.
  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    ESPERA    = 3'd1,
    MEDINDO   = 3'd2,
    AVALIA    = 3'd3,
    RESULTADO = 3'd4
  } estado_t;

  function automatic int nota_w_de(input int num_botoes);
    return (num_botoes > 1) ? $clog2(num_botoes) : 1;
  endfunction

  // One extra bit keeps esp + tolerance from wrapping at the largest duration code.
  function automatic int dur_w_de(input int tempo_w, input int unidade, input int tol_alto);
    return $clog2(((1 << tempo_w) - 1) * unidade + tol_alto + 1) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/avaliador_nota_tempo_codificador_botoes.sv
// codificador_botoes: lowest pressed index, any-pressed and more-than-one flags.
// Rev 1.0
`default_nettype none

module codificador_botoes #(
  parameter int NUM_BOTOES = 12,
  parameter int NOTA_W     = 4
) (
  input  logic [NUM_BOTOES-1:0] botoes,
  output logic [NOTA_W-1:0]     indice,
  output logic                  algum,
  output logic                  multiplos
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    indice = '0;
    for (int i = NUM_BOTOES - 1; i >= 0; i--) begin
      if (botoes[i]) indice = NOTA_W'(i);
    end
  end

  assign algum     = |botoes;
  assign multiplos = |(botoes & (botoes - NUM_BOTOES'(1)));

endmodule

`default_nettype wire

// File: rtl/avaliador_nota_tempo.sv
// avaliador_nota_tempo: measures which button is held and for how long, then grades the press.
// Rev 1.0
`default_nettype none

module avaliador_nota_tempo
  import avaliador_nota_tempo_pkg::*;
#(
  parameter int CLOCK_FREQ     = 5000,
  parameter int NUM_BOTOES     = 12,
  parameter int TEMPO_W        = 4,
  parameter int UNIDADE_CICLOS = CLOCK_FREQ / 4,
  parameter int TOL_BAIXO      = CLOCK_FREQ / 10,
  parameter int TOL_ALTO       = CLOCK_FREQ / 4,
  parameter int TIMEOUT_CICLOS = 5 * CLOCK_FREQ,
  // Derived widths; leave at their defaults.
  parameter int NOTA_W         = nota_w_de(NUM_BOTOES),
  parameter int DUR_W          = dur_w_de(TEMPO_W, UNIDADE_CICLOS, TOL_ALTO)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  habilita,
  input  logic [NUM_BOTOES-1:0] botoes,
  input  logic [NOTA_W-1:0]     nota_esperada,
  input  logic [TEMPO_W-1:0]    tempo_esperado,
  input  logic                  tolerancia_on,
  output logic                  pronto,
  output logic                  nota_correta,
  output logic                  tempo_correto,
  output logic                  timeout,
  output logic                  multiplas,
  output logic [NOTA_W-1:0]     nota_medida,
  output logic [DUR_W-1:0]      duracao_medida,
  output logic [2:0]            db_estado
);

  localparam int ESPERA_W = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [ESPERA_W-1:0] LIMITE_ESPERA = ESPERA_W'(TIMEOUT_CICLOS);
  localparam logic [DUR_W-1:0] UNIDADE = DUR_W'(UNIDADE_CICLOS);
  localparam logic [DUR_W-1:0] MEIA_U  = DUR_W'(UNIDADE_CICLOS / 2);
  localparam logic [DUR_W-1:0] TOL_B   = DUR_W'(TOL_BAIXO);
  localparam logic [DUR_W-1:0] TOL_A   = DUR_W'(TOL_ALTO);

  estado_t               estado;
  logic [NOTA_W-1:0]     nota_esp_q;
  logic [TEMPO_W-1:0]    tempo_esp_q;
  logic                  tol_q;
  logic [NUM_BOTOES-1:0] padrao;
  logic [ESPERA_W-1:0]   cnt_espera;

  logic [NOTA_W-1:0]     indice;
  logic                  algum;
  logic                  multiplos;

  codificador_botoes #(
    .NUM_BOTOES (NUM_BOTOES),
    .NOTA_W     (NOTA_W)
  ) u_codificador (
    .botoes    (botoes),
    .indice    (indice),
    .algum     (algum),
    .multiplos (multiplos)
  );

  logic [ESPERA_W-1:0] espera_prox;
  logic [DUR_W-1:0]    esp;
  logic [DUR_W-1:0]    tol_min, tol_max, est_min, est_max;
  logic                tempo_ok;

  assign espera_prox = cnt_espera + ESPERA_W'(1);
  assign esp         = DUR_W'(tempo_esp_q) * UNIDADE;
  // Lower bounds floor at zero rather than wrapping for short expected durations.
  assign tol_min     = (esp > TOL_B)  ? esp - TOL_B  : '0;
  assign tol_max     = esp + TOL_A;
  assign est_min     = (esp > MEIA_U) ? esp - MEIA_U : '0;
  assign est_max     = esp + MEIA_U;
  assign tempo_ok    = (duracao_medida != '1) &&
                       (tol_q ? (duracao_medida >= tol_min && duracao_medida <= tol_max)
                              : (duracao_medida >= est_min && duracao_medida <  est_max));

  assign db_estado = estado;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado         <= OCIOSO;
      pronto         <= 1'b0;
      nota_correta   <= 1'b0;
      tempo_correto  <= 1'b0;
      timeout        <= 1'b0;
      multiplas      <= 1'b0;
      nota_medida    <= '0;
      duracao_medida <= '0;
      nota_esp_q     <= '0;
      tempo_esp_q    <= '0;
      tol_q          <= 1'b0;
      padrao         <= '0;
      cnt_espera     <= '0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (habilita) begin
            estado         <= ESPERA;
            nota_correta   <= 1'b0;
            tempo_correto  <= 1'b0;
            timeout        <= 1'b0;
            multiplas      <= 1'b0;
            nota_medida    <= '0;
            duracao_medida <= '0;
            nota_esp_q     <= nota_esperada;
            tempo_esp_q    <= tempo_esperado;
            tol_q          <= tolerancia_on;
            cnt_espera     <= '0;
          end
        end
        ESPERA: begin
          cnt_espera <= espera_prox;
          if (!habilita) begin
            estado <= OCIOSO;
          end else if (algum) begin
            // A press on the timeout edge still wins.
            estado         <= MEDINDO;
            duracao_medida <= DUR_W'(1);
            nota_medida    <= indice;
            multiplas      <= multiplos;
            padrao         <= botoes;
          end else if (espera_prox >= LIMITE_ESPERA) begin
            estado        <= RESULTADO;
            timeout       <= 1'b1;
            nota_correta  <= 1'b0;
            tempo_correto <= 1'b0;
            multiplas     <= 1'b0;
          end
        end
        MEDINDO: begin
          if (!habilita) begin
            estado         <= OCIOSO;
            multiplas      <= 1'b0;
            nota_medida    <= '0;
            duracao_medida <= '0;
          end else if (algum) begin
            if (duracao_medida != '1) duracao_medida <= duracao_medida + DUR_W'(1);
            if (botoes != padrao) multiplas <= 1'b1;
          end else begin
            estado <= AVALIA;
          end
        end
        AVALIA: begin
          estado        <= RESULTADO;
          nota_correta  <= !multiplas && (nota_medida == nota_esp_q);
          tempo_correto <= tempo_ok;
        end
        RESULTADO: begin
          estado <= OCIOSO;
          pronto <= 1'b1;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/avaliador_nota_tempo.md
# avaliador_nota_tempo

Parametrised note-and-duration evaluator for the music-memory game datapath. It measures how long the player holds a button and which button it was, then grades the press against the expected note and duration. Each press gets a single-cycle result strobe. The block generalises the fixed 12-button, fixed-tolerance check in the current top level: button count, duration unit and tolerances are all parameters, and it adds a strict/tolerant mode, detection of multiple simultaneous buttons, and a no-press timeout. It sits between the button inputs and the game control unit.

## Interface
- CLOCK_FREQ, 5000: clock frequency in Hz.
- NUM_BOTOES, 12: number of note buttons.
- TEMPO_W, 4: width of the expected-duration code.
- UNIDADE_CICLOS, CLOCK_FREQ/4: cycles per duration unit.
- TOL_BAIXO, CLOCK_FREQ/10: tolerance below the expected duration, in cycles.
- TOL_ALTO, CLOCK_FREQ/4: tolerance above the expected duration, in cycles.
- TIMEOUT_CICLOS, 5*CLOCK_FREQ: maximum wait for a press.
- Derived widths: NOTA_W = clog2(NUM_BOTOES); DUR_W = clog2((2^TEMPO_W−1)·UNIDADE_CICLOS + TOL_ALTO + 1) + 1.

Ports:
- clock  in  1  single system clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high.
- habilita  in  1  level; arms the evaluator and keeps it armed.
- botoes  in  NUM_BOTOES  one bit per button, already debounced.
- nota_esperada  in  NOTA_W  index of the expected button.
- tempo_esperado  in  TEMPO_W  expected duration, in units.
- tolerancia_on  in  1  1 = tolerant window; 0 = strict (rounded-unit) window.
- pronto  out  1  one-cycle pulse when the result is valid.
- nota_correta, tempo_correto, timeout, multiplas  out  1 each  result flags.
- nota_medida  out  NOTA_W  index of the lowest pressed bit.
- duracao_medida  out  DUR_W  measured hold time in cycles, saturating.
- db_estado  out  3  current FSM state code.

## Operation
- States: OCIOSO → ESPERA → MEDINDO → AVALIA → RESULTADO → OCIOSO.
- OCIOSO:
  - On habilita=1, go to ESPERA.
  - On that edge, clear all result outputs and capture nota_esperada, tempo_esperado and tolerancia_on.
  - esp = tempo_esperado·UNIDADE_CICLOS, computed at DUR_W width.
- ESPERA:
  - Wait counter runs.
  - If botoes≠0: go to MEDINDO, set duration counter to 1, capture nota_medida = lowest set bit, set multiplas = (popcount > 1), and latch the pattern.
  - If the wait count reaches TIMEOUT_CICLOS with no press: set timeout=1, set all other flags to 0, go to RESULTADO.
- MEDINDO:
  - While botoes≠0: increment the duration counter, saturating at all-ones.
  - If botoes≠0 and differs from the latched pattern: set multiplas=1 (sticky).
  - When botoes=0: go to AVALIA.
- AVALIA:
  - nota_correta = !multiplas && nota_medida==nota_esperada.
  - Tolerant mode: tempo_correto = max(esp−TOL_BAIXO, 0) ≤ dur ≤ esp+TOL_ALTO.
  - Strict mode: tempo_correto = esp−U/2 ≤ dur < esp+U/2, where U = UNIDADE_CICLOS; the lower bound floors at 0.
  - A saturated counter always gives tempo_correto=0.
- RESULTADO: assert pronto for one cycle, then go to OCIOSO.
- Result outputs hold until the next arm or a reset.
- habilita=0 in ESPERA or MEDINDO aborts to OCIOSO with no pronto; outputs keep their cleared values.
- Buttons already held when the block is armed count as a press starting in ESPERA.

## Timing
- Reset drives every output to 0, the FSM to OCIOSO, and all counters to 0.
- Reset beats every other condition in the same cycle, including mid-MEDINDO: no pronto is produced.
- Duration: a press sampled nonzero on N consecutive edges gives duracao_medida=N.
- pronto rises 2 cycles after the first edge that samples botoes=0 (AVALIA, then RESULTADO).
- Timeout: pronto comes 1 cycle after the wait count reaches TIMEOUT_CICLOS.
- A press on the same edge the timeout is reached takes priority over the timeout.
- habilita held high across RESULTADO causes an immediate re-arm the cycle after pronto.

## Structure
- Shared package/include holds:
  - state codes (OCIOSO=0, ESPERA=1, MEDINDO=2, AVALIA=3, RESULTADO=4), which are the db_estado values;
  - the width-derivation constants.
- One sub-module, codificador_botoes (combinational):
  - input: NUM_BOTOES vector;
  - outputs: lowest-set index, any-pressed, more-than-one.
- Counters and the FSM stay in the top module.

## Test plan
Defaults throughout: tempo_esperado=6 (esp=7500), nota_esperada=2.

1. Hold 0x004 for 7500 cycles → pronto; nota_correta=1, tempo_correto=1, duracao_medida=7500.
2. Hold 0x004 for 3000 cycles → nota_correta=1, tempo_correto=0.
3. Tolerant-window boundaries:
   - 7000 and 8750 cycles → tempo_correto=1;
   - 6999 and 8751 cycles → tempo_correto=0;
   - 7120 and 8500 cycles → tempo_correto=1.
4. Strict mode (tolerancia_on=0):
   - 6875 cycles → tempo_correto=1;
   - 6874 and 8125 cycles → tempo_correto=0.
5. Wrong or multiple buttons:
   - Press 0x014 → multiplas=1, nota_correta=0, nota_medida=2.
   - Press 0x010 alone → nota_medida=4, nota_correta=0.
6. Timeout and aborts:
   - Arm with no press → timeout=1 and pronto exactly 25001 cycles after arming.
   - Reset after 4000 cycles in MEDINDO → all outputs 0, no pronto.
   - habilita dropped mid-press → no pronto.
